xor2_gate: RTL and testbench
============================

// Module: xor2_gate
// PURPOSE
// - Bitwise 2-input XOR datapath cell: f = a ^ b, combinational, zero latency.
// - Adds a registered copy of the result plus compare statistics: parity,
//   Hamming distance and a saturating mismatch counter.
// - Used as a basic logic primitive and as an operand-compare element;
//   WIDTH=1 is the plain xor2 gate.
// PARAMETERS
// - WIDTH      default 1   operand width in bits (legal range 1..64)
// - CNT_W      default 16  width of mismatch counter mis_cnt_q
// PORTS
// - Clk        in   1                  system clock, rising edge
// - Reset_n    in   1                  reset, synchronous, active-low
// - a          in   WIDTH              operand A
// - b          in   WIDTH              operand B
// - en         in   1                  capture strobe for all registered outputs
// - clr        in   1                  synchronous clear of mis_cnt_q
// - f          out  WIDTH              a ^ b, combinational
// - f_q        out  WIDTH              registered a ^ b
// - parity_q   out  1                  registered XOR-reduce of (a ^ b)
// - hd_q       out  $clog2(WIDTH+1)    registered popcount of (a ^ b)
// - mis_cnt_q  out  CNT_W              count of captured cycles where a != b
// - valid_q    out  1                  en delayed one cycle
// BEHAVIOUR
// - Interface: one clock (Clk); reset is synchronous and active-low (Reset_n).
// - f: purely combinational; it follows a/b with no clock dependence and is valid
//   while Reset_n=0. Truth table per bit: 00->0, 10->1, 01->1, 11->0.
// - Reset (Reset_n=0 at a rising Clk edge): f_q=0, parity_q=0, hd_q=0,
//   mis_cnt_q=0, valid_q=0. Reset has priority over en and clr.
// - en=1 at an edge: f_q<=a^b, parity_q<=^(a^b), hd_q<=popcount(a^b),
//   valid_q<=1. Latency is 1 cycle from a/b to the registered outputs.
// - en=0 at an edge: f_q/parity_q/hd_q hold; valid_q<=0.
// - mis_cnt_q increments when en=1 and (a^b)!=0.
//   It saturates at all-ones and does not wrap.
// - clr=1 sets mis_cnt_q<=0. If en=1 and clr=1 in the same cycle, the
//   counter is cleared and the count starts at 0 (no increment that cycle).
//   clr does not affect the other registers.
// - Deasserting reset mid-stream: the first edge with Reset_n=1 behaves normally.
//   No state is carried over from before reset.
// - hd_q range 0..WIDTH. For WIDTH=1, hd_q and parity_q both equal f_q.
// - No X-propagation masking: X on a/b propagates to f.
// STRUCTURE
// - xor2_pkg: functions for the hd_q width ($clog2(WIDTH+1)) and for
//   counter saturation, plus the CNT_W default constant.
// - Sub-module popcount (parameter WIDTH): combinational adder tree
//   that feeds hd_q.
// - The rest is one always_ff block plus continuous assigns.
// TESTING
// - WIDTH=1, no clock dependence: (a,b)=00/10/01/11 -> f=0/1/1/0, each
//   checked 20 ns after the change. Required error count is 0.
// - WIDTH=8, en=1: a=8'hF0, b=8'h3C -> next edge f_q=8'hCC,
//   hd_q=4, parity_q=0, valid_q=1.
// - Hold/latency: en pulses for one cycle with a=8'h01, b=8'h00. Then a and b
//   change with en=0. Required: f_q stays 8'h01, valid_q falls 1 cycle later.
// - Counter: 5 cycles with en=1 and a!=b, then 3 cycles with a==b -> mis_cnt_q=5.
//   Assert clr and en together -> mis_cnt_q=0.
// - Saturation: CNT_W=2, 6 mismatching captures -> mis_cnt_q holds at 3.
// - Reset mid-operation: Reset_n=0 for one edge while en=1 -> all registered
//   outputs 0. f still equals a^b during reset.

Source files
------------

// File: rtl/xor2_gate_pkg.sv
// Shared constants and helpers for the xor2_gate compare cell.
// Covers the Hamming-distance port width and the saturating counter step.
package xor2_gate_pkg;

  localparam int CNT_W_DEF = 16;

  // Width needed to hold a popcount of 0..w.
  function automatic int hd_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Increment v, clamped at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] mx;
    mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= mx) ? mx : v + 64'd1;
  endfunction

endpackage

// File: rtl/xor2_gate_if.sv
// Operand / result bundle for xor2_gate; the master drives operands and strobes.
interface xor2_gate_if
  import xor2_gate_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int HD_W = hd_width(WIDTH);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_q;
  logic             parity_q;
  logic [HD_W-1:0]  hd_q;
  logic [CNT_W-1:0] mis_cnt_q;
  logic             valid_q;

  modport master (
    output a, b, en, clr,
    input  f, f_q, parity_q, hd_q, mis_cnt_q, valid_q
  );

  modport slave (
    input  a, b, en, clr,
    output f, f_q, parity_q, hd_q, mis_cnt_q, valid_q
  );
endinterface

// File: rtl/xor2_gate_popcount.sv
// Combinational popcount as a balanced adder tree; leaves padded to a power of two.
module xor2_gate_popcount
  import xor2_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]           x,
  output logic [hd_width(WIDTH)-1:0] cnt
);
  localparam int HW = hd_width(WIDTH);
  localparam int L  = $clog2(WIDTH);
  localparam int N  = 1 << L;

  // Every partial sum is bounded by WIDTH, so HW bits suffice at every level.
  for (genvar k = 0; k <= L; k++) begin : lv
    logic [HW-1:0] s [N >> k];
    for (genvar i = 0; i < (N >> k); i++) begin : nd
      if (k == 0) begin : leaf
        if (i < WIDTH) begin : bit_in
          assign s[i] = HW'(x[i]);
        end else begin : pad
          assign s[i] = '0;
        end
      end else begin : add
        assign s[i] = lv[k-1].s[2*i] + lv[k-1].s[2*i+1];
      end
    end
  end

  assign cnt = lv[L].s[0];
endmodule

// File: rtl/xor2_gate.sv
// Bitwise XOR cell with registered result, parity, Hamming distance and a
// saturating mismatch counter.
module xor2_gate
  import xor2_gate_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  xor2_gate_if.slave  bus
);
  localparam int HD_W   = hd_width(WIDTH);
  localparam int STAGES = 1;

  logic [WIDTH-1:0] x;
  logic [HD_W-1:0]  pc;
  logic [WIDTH-1:0] f_q;
  logic             parity_q;
  logic [HD_W-1:0]  hd_q;
  logic [CNT_W-1:0] cnt_q;
  logic [STAGES:0]  vld_pipe;

  assign x = bus.a ^ bus.b;

  xor2_gate_popcount #(.WIDTH(WIDTH)) u_pc (
    .x   (x),
    .cnt (pc)
  );

  assign vld_pipe[0] = bus.en;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      f_q                 <= '0;
      parity_q            <= 1'b0;
      hd_q                <= '0;
      cnt_q               <= '0;
      vld_pipe[STAGES:1]  <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (bus.en) begin
        f_q      <= x;
        parity_q <= ^x;
        hd_q     <= pc;
      end
      // Clear wins over a same-cycle mismatch so the count restarts at 0.
      if (bus.clr)
        cnt_q <= '0;
      else if (bus.en && (|x))
        cnt_q <= CNT_W'(sat_inc(64'(cnt_q), CNT_W));
    end
  end

  assign bus.f         = x;
  assign bus.f_q       = f_q;
  assign bus.parity_q  = parity_q;
  assign bus.hd_q      = hd_q;
  assign bus.mis_cnt_q = cnt_q;
  assign bus.valid_q   = vld_pipe[STAGES];
endmodule

// File: tb/tb_xor2_gate.sv
// Directed bench for xor2_gate: 1-bit gate, 8-bit compare and 2-bit saturating counter.
module tb_xor2_gate;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  xor2_gate_if #(.WIDTH(1), .CNT_W(16)) i1 ();
  xor2_gate_if #(.WIDTH(8), .CNT_W(16)) i8 ();
  xor2_gate_if #(.WIDTH(8), .CNT_W(2))  is ();

  xor2_gate #(.WIDTH(1), .CNT_W(16)) u1 (.Clk(Clk), .Reset_n(Reset_n), .bus(i1));
  xor2_gate #(.WIDTH(8), .CNT_W(16)) u8 (.Clk(Clk), .Reset_n(Reset_n), .bus(i8));
  xor2_gate #(.WIDTH(8), .CNT_W(2))  us (.Clk(Clk), .Reset_n(Reset_n), .bus(is));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_chk();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    i1.a = '0; i1.b = '0; i1.en = 0; i1.clr = 0;
    i8.a = '0; i8.b = '0; i8.en = 0; i8.clr = 0;
    is.a = '0; is.b = '0; is.en = 0; is.clr = 0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_f_q",    64'(i8.f_q), 64'h0);
    chk("rst_hd",     64'(i8.hd_q), 64'h0);
    chk("rst_par",    64'(i8.parity_q), 64'h0);
    chk("rst_valid",  64'(i8.valid_q), 64'h0);
    chk("rst_cnt",    64'(i8.mis_cnt_q), 64'h0);
    chk("rst_cnt_s",  64'(is.mis_cnt_q), 64'h0);

    // 1-bit truth table, combinational (also valid during reset)
    i1.a = 1'b0; i1.b = 1'b0; #20; chk("tt00", 64'(i1.f), 64'h0);
    i1.a = 1'b1; i1.b = 1'b0; #20; chk("tt10", 64'(i1.f), 64'h1);
    i1.a = 1'b0; i1.b = 1'b1; #20; chk("tt01", 64'(i1.f), 64'h1);
    i1.a = 1'b1; i1.b = 1'b1; #20; chk("tt11", 64'(i1.f), 64'h0);

    @(negedge Clk);
    Reset_n = 1'b1;

    // 8-bit capture F0 ^ 3C
    i8.a = 8'hF0; i8.b = 8'h3C; i8.en = 1;
    #1 chk("f_cc", 64'(i8.f), 64'hCC);
    edge_chk();
    chk("fq_cc",  64'(i8.f_q), 64'hCC);
    chk("hd_cc",  64'(i8.hd_q), 64'd4);
    chk("par_cc", 64'(i8.parity_q), 64'h0);
    chk("vld_cc", 64'(i8.valid_q), 64'h1);
    chk("cnt_1",  64'(i8.mis_cnt_q), 64'd1);

    // Hold / latency
    @(negedge Clk);
    i8.a = 8'h01; i8.b = 8'h00; i8.en = 1;
    edge_chk();
    chk("fq_01",  64'(i8.f_q), 64'h01);
    chk("hd_01",  64'(i8.hd_q), 64'd1);
    chk("par_01", 64'(i8.parity_q), 64'h1);
    chk("vld_01", 64'(i8.valid_q), 64'h1);
    @(negedge Clk);
    i8.a = 8'hFF; i8.b = 8'h00; i8.en = 0;
    edge_chk();
    chk("hold_fq",  64'(i8.f_q), 64'h01);
    chk("hold_hd",  64'(i8.hd_q), 64'd1);
    chk("hold_vld", 64'(i8.valid_q), 64'h0);
    chk("hold_cnt", 64'(i8.mis_cnt_q), 64'd2);

    // clr alone: counter clears, other registers untouched
    @(negedge Clk);
    i8.clr = 1;
    edge_chk();
    chk("clr_cnt", 64'(i8.mis_cnt_q), 64'd0);
    chk("clr_fq",  64'(i8.f_q), 64'h01);
    @(negedge Clk);
    i8.clr = 0;

    // 5 mismatches then 3 matches
    for (int i = 0; i < 5; i++) begin
      i8.a = 8'(i + 1); i8.b = 8'h00; i8.en = 1;
      @(negedge Clk);
    end
    for (int i = 0; i < 3; i++) begin
      i8.a = 8'h5A; i8.b = 8'h5A;
      @(negedge Clk);
    end
    chk("cnt_5",   64'(i8.mis_cnt_q), 64'd5);
    chk("fq_eq",   64'(i8.f_q), 64'h00);
    chk("hd_eq",   64'(i8.hd_q), 64'd0);

    // clr and en together with a mismatch
    i8.a = 8'h0F; i8.b = 8'h00; i8.clr = 1;
    edge_chk();
    chk("clr_en_cnt", 64'(i8.mis_cnt_q), 64'd0);
    chk("clr_en_fq",  64'(i8.f_q), 64'h0F);
    chk("clr_en_hd",  64'(i8.hd_q), 64'd4);
    @(negedge Clk);
    i8.clr = 0; i8.en = 0;

    // Saturation with a 2-bit counter
    is.a = 8'h80; is.b = 8'h00; is.en = 1;
    edge_chk(); chk("sat_1", 64'(is.mis_cnt_q), 64'd1);
    edge_chk(); chk("sat_2", 64'(is.mis_cnt_q), 64'd2);
    edge_chk(); chk("sat_3", 64'(is.mis_cnt_q), 64'd3);
    edge_chk(); chk("sat_4", 64'(is.mis_cnt_q), 64'd3);
    edge_chk(); chk("sat_5", 64'(is.mis_cnt_q), 64'd3);
    edge_chk(); chk("sat_6", 64'(is.mis_cnt_q), 64'd3);
    chk("sat_hd", 64'(is.hd_q), 64'd1);
    @(negedge Clk);
    is.en = 0;

    // 1-bit registered outputs: hd_q and parity_q track f_q
    i1.a = 1'b1; i1.b = 1'b0; i1.en = 1;
    edge_chk();
    chk("w1_fq",  64'(i1.f_q), 64'h1);
    chk("w1_hd",  64'(i1.hd_q), 64'h1);
    chk("w1_par", 64'(i1.parity_q), 64'h1);
    @(negedge Clk);
    i1.en = 0;

    // Reset mid-operation with en held high
    i8.a = 8'hAA; i8.b = 8'h55; i8.en = 1;
    edge_chk();
    chk("pre_cnt", 64'(i8.mis_cnt_q), 64'd1);
    @(negedge Clk);
    Reset_n = 1'b0;
    edge_chk();
    chk("mr_fq",   64'(i8.f_q), 64'h0);
    chk("mr_hd",   64'(i8.hd_q), 64'h0);
    chk("mr_par",  64'(i8.parity_q), 64'h0);
    chk("mr_vld",  64'(i8.valid_q), 64'h0);
    chk("mr_cnt",  64'(i8.mis_cnt_q), 64'h0);
    chk("mr_cnt_s", 64'(is.mis_cnt_q), 64'h0);
    chk("mr_f",    64'(i8.f), 64'hFF);
    @(negedge Clk);
    Reset_n = 1'b1;
    edge_chk();
    chk("post_fq",  64'(i8.f_q), 64'hFF);
    chk("post_hd",  64'(i8.hd_q), 64'd8);
    chk("post_par", 64'(i8.parity_q), 64'h0);
    chk("post_vld", 64'(i8.valid_q), 64'h1);
    chk("post_cnt", 64'(i8.mis_cnt_q), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
